// File: rtl/twenty_bit_adder.sv
// rtl/twenty_bit_adder.sv - registered 20-bit unsigned adder with a two-level carry-lookahead core
module twenty_bit_adder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [19:0] i0,
    input  logic [19:0] i1,
    output logic [19:0] s,
    output logic        cout,
    output logic        out_valid
);

    // Carry into bit 0 is tied off; the adder has no carry-in port.
    localparam logic C0 = 1'b0;

    logic [19:0] p;
    logic [19:0] g;
    logic [4:0]  grp_g;
    logic [4:0]  grp_p;
    logic [4:0]  grp_cin;
    logic        carry_out;
    logic [19:0] carry;
    logic [19:0] sum;

    logic [19:0] s_q;
    logic [19:0] s_d;
    logic        cout_q;
    logic        cout_d;
    logic        valid_q;
    logic        valid_d;

    // First lookahead level: per-bit propagate/generate and per-group G/P for five nibbles.
    always_comb begin
        p     = i0 ^ i1;
        g     = i0 & i1;
        grp_g = '0;
        grp_p = '0;
        for (int k = 0; k < 5; k++) begin
            grp_g[k] = g[4*k+3]
                     | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            grp_p[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
        end
    end

    // Second lookahead level: every group carry is a flat sum-of-products of group G/P,
    // so no carry has to ripple through an earlier group.
    always_comb begin
        grp_cin    = '0;
        grp_cin[0] = C0;
        grp_cin[1] = grp_g[0] | (grp_p[0] & C0);
        grp_cin[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & C0);
        grp_cin[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                   | (grp_p[2] & grp_p[1] & grp_p[0] & C0);
        grp_cin[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
                   | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                   | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & C0);
        carry_out  = grp_g[4] | (grp_p[4] & grp_g[3]) | (grp_p[4] & grp_p[3] & grp_g[2])
                   | (grp_p[4] & grp_p[3] & grp_p[2] & grp_g[1])
                   | (grp_p[4] & grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                   | (grp_p[4] & grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & C0);
    end

    // Inside each nibble, bit carries are expanded from the group carry-in, then sum = p ^ c.
    always_comb begin
        carry = '0;
        for (int k = 0; k < 5; k++) begin
            carry[4*k]   = grp_cin[k];
            carry[4*k+1] = g[4*k] | (p[4*k] & grp_cin[k]);
            carry[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                         | (p[4*k+1] & p[4*k] & grp_cin[k]);
            carry[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                         | (p[4*k+2] & p[4*k+1] & g[4*k])
                         | (p[4*k+2] & p[4*k+1] & p[4*k] & grp_cin[k]);
        end
        sum = p ^ carry;
    end

    // Next-state: load a new result on an accepted pair, otherwise hold sum/carry and drop valid.
    always_comb begin
        s_d     = s_q;
        cout_d  = cout_q;
        valid_d = 1'b0;
        if (in_valid) begin
            s_d     = sum;
            cout_d  = carry_out;
            valid_d = 1'b1;
        end
    end

    // Output registers; reset clears everything at once, discarding any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q     <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            s_q     <= s_d;
            cout_q  <= cout_d;
            valid_q <= valid_d;
        end
    end

    assign s         = s_q;
    assign cout      = cout_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_twenty_bit_adder.sv
// tb/tb_twenty_bit_adder.sv - scoreboard bench for twenty_bit_adder
module tb_twenty_bit_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [19:0] i0;
    logic [19:0] i1;
    logic [19:0] s;
    logic        cout;
    logic        out_valid;

    typedef struct {
        logic [20:0] exp;
        int          cyc;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int        compared;
    int        mismatched;
    int        cyc;
    bit        done;

    twenty_bit_adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .i0        (i0),
        .i1        (i1),
        .s         (s),
        .cout      (cout),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [20:0] act, input logic [20:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Drive one pair shortly after the rising edge; the following edge captures it.
    task automatic issue(input logic [19:0] a, input logic [19:0] b, input logic v, input logic [20:0] exp);
        sb_entry_t e;
        @(posedge clk);
        #2;
        in_valid = v;
        i0       = a;
        i1       = b;
        if (v) begin
            e.exp = exp;
            e.cyc = cyc;
            sb_q.push_back(e);
        end
    endtask

    // Monitor: every out_valid cycle must match the oldest pending expectation, one cycle after issue.
    always @(negedge clk) begin
        if (rst_n && out_valid && !done) begin
            if (sb_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_out_valid: got sum %h with empty scoreboard", {cout, s});
            end else begin
                sb_entry_t e;
                e = sb_q.pop_front();
                check("sum", {cout, s}, e.exp);
                check("latency", 21'(cyc - e.cyc), 21'd1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] a;
        logic [19:0] b;
        done     = 1'b0;
        cyc      = 0;
        compared = 0;
        mismatched = 0;
        in_valid = 1'b0;
        i0       = '0;
        i1       = '0;
        rst_n    = 1'b0;
        #1;
        check("reset_s", {1'b0, s}, 21'd0);
        check("reset_cout_valid", {19'd0, cout, out_valid}, 21'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Basic sums back-to-back
        issue(20'd0,    20'd0,    1'b1, 21'd0);
        issue(20'd0,    20'd1,    1'b1, 21'd1);
        issue(20'd1,    20'd0,    1'b1, 21'd1);
        issue(20'd111,  20'd222,  1'b1, 21'd333);
        issue(20'd1000, 20'd1000, 1'b1, 21'd2000);
        // Carry propagation and wrap-around
        issue(20'hFFFFF, 20'h00001, 1'b1, 21'h100000);
        issue(20'hFFFFF, 20'hFFFFF, 1'b1, 21'h1FFFFE);
        issue(20'h0FFFF, 20'h00001, 1'b1, 21'h010000);
        issue(20'h0F0F0, 20'h00F10, 1'b1, 21'h010000);
        issue(20'hAAAAA, 20'h55555, 1'b1, 21'h0FFFFF);
        issue(20'h80000, 20'h80000, 1'b1, 21'h100000);

        // Hold: a gap cycle with different operands must not disturb s/cout
        issue(20'd111, 20'd222, 1'b1, 21'd333);
        issue(20'd5,   20'd5,   1'b0, 21'd0);
        @(posedge clk);
        #1;
        check("hold_valid", {20'd0, out_valid}, 21'd0);
        check("hold_sum", {cout, s}, 21'd333);

        // Immediate asynchronous reset mid-cycle with s=333 held
        #5;
        check("pre_reset_sum", {cout, s}, 21'd333);
        rst_n = 1'b0;
        #1;
        check("async_reset_sum", {cout, s}, 21'd0);
        check("async_reset_valid", {20'd0, out_valid}, 21'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Reset mid-stream: the pair presented before reset never produces a result
        @(posedge clk);
        #2;
        in_valid = 1'b1;
        i0       = 20'd1000;
        i1       = 20'd1000;
        #3;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midstream_reset_sum", {cout, s}, 21'd0);
        check("midstream_reset_valid", {20'd0, out_valid}, 21'd0);

        // First pair after reset release is captured normally
        issue(20'd7, 20'd9, 1'b1, 21'd16);

        // Random pairs with random gaps
        for (int n = 0; n < 3000; n++) begin
            a = 20'($urandom);
            b = 20'($urandom);
            if ($urandom_range(0, 3) == 0)
                issue(a, b, 1'b0, 21'd0);
            else
                issue(a, b, 1'b1, {1'b0, a} + {1'b0, b});
        end
        issue(20'd0, 20'd0, 1'b0, 21'd0);
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 21'(sb_q.size()), 21'd0);
        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
